// File: rtl/alu_seq_pkg.sv
// Shared constants for the sliced sequential ALU: op selects and FSM encoding.
package alu_seq_pkg;

    // Logic-mode function selects (m=1); values 8..15 also pass a.
    localparam logic [3:0] LOP_AND    = 4'd0;
    localparam logic [3:0] LOP_OR     = 4'd1;
    localparam logic [3:0] LOP_XOR    = 4'd2;
    localparam logic [3:0] LOP_NAND   = 4'd3;
    localparam logic [3:0] LOP_NOR    = 4'd4;
    localparam logic [3:0] LOP_XNOR   = 4'd5;
    localparam logic [3:0] LOP_NOT_A  = 4'd6;
    localparam logic [3:0] LOP_PASS_B = 4'd7;
    localparam logic [3:0] LOP_PASS_A = 4'd8;

    // Arithmetic-mode select, decoded from s[0] only.
    localparam logic AOP_ADD = 1'b0;
    localparam logic AOP_SUB = 1'b1;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU slice: ripple-carry adder plus bitwise logic mux.
module alu_slice
    import alu_seq_pkg::*;
#(
    parameter int unsigned SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    input  logic [3:0]         s,
    input  logic               m,
    input  logic               cin,
    output logic [SLICE_W-1:0] f_s,
    output logic               cout_s,
    output logic               cmsb_s
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] sum;
    logic [SLICE_W-1:0] lres;
    logic               cy;
    logic               cmsb;

    // Ripple chain; cmsb is the carry entering the slice's top bit.
    always_comb begin
        b_eff = (s[0] == AOP_SUB) ? ~b_s : b_s;
        sum   = '0;
        cy    = cin;
        cmsb  = 1'b0;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            if (i == SLICE_W - 1) begin
                cmsb = cy;
            end
            sum[i] = a_s[i] ^ b_eff[i] ^ cy;
            cy     = (a_s[i] & b_eff[i]) | (cy & (a_s[i] ^ b_eff[i]));
        end
    end

    always_comb begin
        lres = a_s;
        case (s)
            LOP_AND:    lres = a_s & b_s;
            LOP_OR:     lres = a_s | b_s;
            LOP_XOR:    lres = a_s ^ b_s;
            LOP_NAND:   lres = ~(a_s & b_s);
            LOP_NOR:    lres = ~(a_s | b_s);
            LOP_XNOR:   lres = ~(a_s ^ b_s);
            LOP_NOT_A:  lres = ~a_s;
            LOP_PASS_B: lres = b_s;
            default:    lres = a_s;
        endcase
    end

    assign f_s    = m ? lres : sum;
    assign cout_s = m ? 1'b0 : cy;
    assign cmsb_s = m ? 1'b0 : cmsb;

endmodule

// File: rtl/alu_seq_sliced.sv
// Multi-cycle ALU computing WIDTH bits one SLICE_W slice per clock, LS slice first.
// Signed-overflow flag is built only when ALU_SEQ_OVF_EN is defined; otherwise ovf=0.
module alu_seq_sliced
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             p,
    output logic             g,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               cout_q, cout_d;
    logic               p_q, p_d;
    logic               g_q, g_d;
    logic               zero_q, zero_d;

    logic [SLICE_W-1:0] a_sl, b_sl, f_sl;
    logic               cout_sl;
`ifdef ALU_SEQ_OVF_EN
    logic               cmsb_sl;
    logic               ovf_q, ovf_d;
`else
    logic               unused_cmsb;
`endif

    assign a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
    assign b_sl = b_q[idx_q*SLICE_W +: SLICE_W];

    alu_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a_s    (a_sl),
        .b_s    (b_sl),
        .s      (s_q),
        .m      (m_q),
        .cin    (carry_q),
        .f_s    (f_sl),
        .cout_s (cout_sl),
`ifdef ALU_SEQ_OVF_EN
        .cmsb_s (cmsb_sl)
`else
        .cmsb_s (unused_cmsb)
`endif
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        f_d         = f_q;
        s_d         = s_q;
        m_d         = m_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
        p_d         = p_q;
        g_d         = g_q;
        zero_d      = zero_q;
`ifdef ALU_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    carry_d = m ? 1'b0 : cn;
                    idx_d   = '0;
                    p_d     = |(a | b);
                    g_d     = &(a & b);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                f_d[idx_q*SLICE_W +: SLICE_W] = f_sl;
                carry_d = cout_sl;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (idx_q == IDX_LAST) begin
                    cout_d      = cout_sl;
                    zero_d      = (f_d == '0);
`ifdef ALU_SEQ_OVF_EN
                    ovf_d       = cmsb_sl ^ cout_sl;
`endif
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            p_q         <= 1'b0;
            g_q         <= 1'b0;
            zero_q      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            s_q         <= s_d;
            m_q         <= m_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            p_q         <= p_d;
            g_q         <= g_d;
            zero_q      <= zero_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign cout      = cout_q;
    assign p         = p_q;
    assign g         = g_q;
    assign zero      = zero_q;
`ifdef ALU_SEQ_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_sliced.sv
// Directed bench for alu_seq_sliced with a word-level reference model and per-cycle result checker.
module tb_alu_seq_sliced;

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned NS = W / SW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid, in_ready, m, cn;
    logic         out_valid, out_ready, cout, p, g, zero, ovf;
    logic [W-1:0] a, b, f;
    logic [3:0]   s;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_f;
    logic         exp_cout, exp_zero, exp_ovf, exp_p, exp_g;

    always #5 clk = ~clk;

    alu_seq_sliced #(
        .WIDTH   (W),
        .SLICE_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cn        (cn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .p         (p),
        .g         (g),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Whole-word reference: plain arithmetic on WIDTH+1 bits and bitwise ops.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic [3:0] ms, input logic mm, input logic mcn);
        logic [W:0]   sum;
        logic [W-1:0] bb;
        exp_p = |(ma | mb);
        exp_g = &(ma & mb);
        if (!mm) begin
            bb       = ms[0] ? ~mb : mb;
            sum      = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mcn};
            exp_f    = sum[W-1:0];
            exp_cout = sum[W];
            exp_ovf  = (ma[W-1] == bb[W-1]) && (sum[W-1] != ma[W-1]);
        end else begin
            case (ms)
                4'd0:    exp_f = ma & mb;
                4'd1:    exp_f = ma | mb;
                4'd2:    exp_f = ma ^ mb;
                4'd3:    exp_f = ~(ma & mb);
                4'd4:    exp_f = ~(ma | mb);
                4'd5:    exp_f = ~(ma ^ mb);
                4'd6:    exp_f = ~ma;
                4'd7:    exp_f = mb;
                default: exp_f = ma;
            endcase
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end
`ifndef ALU_SEQ_OVF_EN
        exp_ovf = 1'b0;
`endif
        exp_zero = (exp_f == '0);
    endtask

    // Every cycle a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            chk("cmp_f", 32'(f), 32'(exp_f));
            chk("cmp_cout", 32'(cout), 32'(exp_cout));
            chk("cmp_zero", 32'(zero), 32'(exp_zero));
            chk("cmp_ovf", 32'(ovf), 32'(exp_ovf));
            chk("cmp_p", 32'(p), 32'(exp_p));
            chk("cmp_g", 32'(g), 32'(exp_g));
            chk("cmp_in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [3:0] ts, input logic tm, input logic tcn,
                         input logic [W-1:0] lf, input logic lcout, input logic lzero,
                         input logic lovf, input int hold);
        int k;
        int lat;
        model(ta, tb_, ts, tm, tcn);
        @(negedge clk);
        a = ta; b = tb_; s = ts; m = tm; cn = tcn; in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(NS));
        chk("lit_f", 32'(f), 32'(lf));
        chk("lit_cout", 32'(cout), 32'(lcout));
        chk("lit_zero", 32'(zero), 32'(lzero));
`ifdef ALU_SEQ_OVF_EN
        chk("lit_ovf", 32'(ovf), 32'(lovf));
`else
        chk("lit_ovf", 32'(ovf), 32'd0);
`endif
        if (hold > 0) begin
            // Stall the consumer and offer a conflicting op that must be ignored.
            out_ready = 1'b0;
            a = 16'h0F0F; b = 16'h3333; s = 4'd1; m = 1'b1; in_valid = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_f", 32'(f), 32'(lf));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_flags", {26'd0, cout, p, g, zero, ovf, 1'b0}, 32'd0);
        rst = 1'b0;

        do_op(16'h00FF, 16'h0001, 4'd0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 4'd1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h0007, 16'h0005, 4'd1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 4'd0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 0);
        do_op(16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        do_op(16'hA5A5, 16'hFFFF, 4'd2, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0);
        chk("lit_p_xor", 32'(p), 32'd1);
        chk("lit_g_xor", 32'(g), 32'd0);
        do_op(16'hA5A5, 16'hFFFF, 4'd9, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFF, 4'd0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        chk("lit_g_and", 32'(g), 32'd1);
        do_op(16'h0F0F, 16'h00F0, 4'd6, 1'b1, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h0F0F, 16'h00F0, 4'd4, 1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h1111, 4'd0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 3);

        // Abort an op after two slices have been processed.
        model(16'h1234, 16'h4321, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; s = 4'd0; m = 1'b0; cn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_f", 32'(f), 32'd0);
        rst = 1'b0;

        do_op(16'h8000, 16'h8000, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
